sc_et_sched: RTL

Early-termination scheduler for a stochastic-computing datapath. It accepts a job with a requested precision and drives a bypass-masked counter that enumerates only the top `prec` bits of a WIDTH-bit RNS/sample index. It streams one sample index per enabled cycle to the SNG bank and retires the job on natural wrap or on an external convergence stop. It then reports the issued sample count through a done handshake.

---
 rtl/sc_et_pkg.sv | 24 ++
 rtl/sc_et_sched_bypass_ctr_en.sv | 37 +++
 rtl/sc_et_sched.sv | 88 ++++++++
 3 files changed

// File: rtl/sc_et_pkg.sv
// Shared types and helpers for the early-termination stochastic-computing scheduler.
package sc_et_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 32;

  // Bypass mask: the low (w - p) bits are skipped; p is clamped to w.
  function automatic logic [MAX_W-1:0] prec_to_bp(input int unsigned p, input int unsigned w);
    int unsigned pc;
    logic [MAX_W-1:0] m;
    pc = (p > w) ? w : p;
    m  = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w - pc) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sc_et_sched_bypass_ctr_en.sv
// Bypass-masked up-counter: only bits with bp=0 count, carries ripple through bypassed bits.
module bypass_ctr_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [WIDTH-1:0] bp,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] next;

  always_comb begin
    carry[0] = 1'b1;
    for (int i = 1; i <= WIDTH; i++) begin
      carry[i] = carry[i-1] & (cnt[i-1] | bp[i-1]);
    end
    next = cnt ^ (carry[WIDTH-1:0] & ~bp);
  end

  assign wrap = carry[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= next;
    end
  end

endmodule

// File: rtl/sc_et_sched.sv
// Early-termination scheduler: streams masked sample indices and reports the issued count.
module sc_et_sched
  import sc_et_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PW-1:0]    start_prec,
  input  logic             en,
  input  logic             term_req,
  output logic             samp_valid,
  output logic [WIDTH-1:0] samp_cnt,
  output logic             samp_last,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH:0]   done_nsamp,
  output logic             done_early
);

  state_t           state;
  logic [WIDTH-1:0] bp;
  logic [WIDTH:0]   nsamp;
  logic             wrap;
  logic             accept;
  logic             adv;
  logic [MAX_W-1:0] bp_full;
  logic             bp_unused;

  assign bp_full   = prec_to_bp(int'(start_prec), WIDTH);
  assign bp_unused = ^bp_full[MAX_W-1:WIDTH];

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign accept      = start_ready & start_valid;
  assign samp_valid  = (state == RUN) & en;
  assign samp_last   = samp_valid & (wrap | term_req);
  // The counter freezes on the final sample so samp_cnt keeps the last index.
  assign adv         = samp_valid & ~samp_last;

  bypass_ctr_en #(.WIDTH(WIDTH)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .adv   (adv),
    .bp    (bp),
    .cnt   (samp_cnt),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bp         <= '0;
      nsamp      <= '0;
      done_nsamp <= '0;
      done_early <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            bp    <= bp_full[WIDTH-1:0];
            nsamp <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            nsamp <= nsamp + (WIDTH+1)'(1);
            if (samp_last) begin
              done_nsamp <= nsamp + (WIDTH+1)'(1);
              done_early <= term_req & ~wrap;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
